sat_combiner: RTL and testbench

Sums the complex sample streams of up to NUM_CHAN `sat_chan` instances, adds scaled pseudo-Gaussian noise, rescales and saturates to a 16-bit complex output for the DAC/output interface. Sits directly downstream of the `sat_chan` array in the GPS synthesizer. It has a fixed 3-cycle pipeline, per-channel enables and a saturating overflow counter for gain tuning.

---
 rtl/gps_synth_pkg.sv | 23 ++
 rtl/sat_combiner_noise_gen.sv | 46 ++++
 rtl/sat_combiner.sv | 141 ++++++++++++++
 tb/tb_sat_combiner.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gps_synth_pkg.sv
// Shared GPS synthesizer definitions: sample width, noise LFSR constants and
// the complex-sample type used between the channel array and the combiner.
package gps_synth_pkg;

    localparam int SAMPLE_W = 16;

    localparam logic [31:0] LFSR_POLY     = 32'h8020_0003;
    localparam logic [31:0] NOISE_SEED_RE = 32'h1234_5678;
    localparam logic [31:0] NOISE_SEED_IM = 32'h9ABC_DEF0;

    typedef struct packed {
        logic signed [SAMPLE_W-1:0] re;
        logic signed [SAMPLE_W-1:0] im;
    } cplx_t;

    localparam cplx_t CPLX_ZERO = 32'h0000_0000;

    // One Galois step, shifting towards bit 0.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0000_0000);
    endfunction

endpackage

// File: rtl/sat_combiner_noise_gen.sv
// noise_gen: pair of Galois LFSRs producing a gain-scaled pseudo-Gaussian
// complex noise sample; only built when SAT_COMBINER_NOISE_EN is defined.
module noise_gen
    import gps_synth_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       advance,
    input  logic [15:0]                gain,
    output logic signed [SAMPLE_W-1:0] noise_re,
    output logic signed [SAMPLE_W-1:0] noise_im
);

    logic [31:0] lfsr_re_r;
    logic [31:0] lfsr_im_r;

    // Sum of four signed bytes approximates a Gaussian; the 26-bit product
    // cannot overflow and bits [25:10] always fit in 16 signed bits.
    function automatic logic signed [SAMPLE_W-1:0] scale_noise(
        input logic [31:0] s,
        input logic [15:0] g
    );
        logic signed [9:0]  n;
        logic signed [25:0] p;
        n = {{2{s[7]}},  s[7:0]}   + {{2{s[15]}}, s[15:8]} +
            {{2{s[23]}}, s[23:16]} + {{2{s[31]}}, s[31:24]};
        p = n * $signed({1'b0, g});
        return p[25:10];
    endfunction

    // LFSRs step and the output register loads only when a sample is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_re_r <= NOISE_SEED_RE;
            lfsr_im_r <= NOISE_SEED_IM;
            noise_re  <= 16'sd0;
            noise_im  <= 16'sd0;
        end else if (advance) begin
            lfsr_re_r <= lfsr_step(lfsr_re_r);
            lfsr_im_r <= lfsr_step(lfsr_im_r);
            noise_re  <= scale_noise(lfsr_re_r, gain);
            noise_im  <= scale_noise(lfsr_im_r, gain);
        end
    end

endmodule

// File: rtl/sat_combiner.sv
// sat_combiner: sums enabled channel samples plus optional noise, rescales and
// saturates to 16 bits with a 3-cycle pipeline. Noise: SAT_COMBINER_NOISE_EN.
module sat_combiner
    import gps_synth_pkg::*;
#(
    parameter int NUM_CHAN  = 8,
    parameter int OUT_SHIFT = 3
)(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         dv_in,
    input  logic [NUM_CHAN*SAMPLE_W-1:0] real_in,
    input  logic [NUM_CHAN*SAMPLE_W-1:0] imag_in,
    input  logic [NUM_CHAN-1:0]          chan_en,
    input  logic [15:0]                  noise_gain,
    input  logic                         ovf_clr,
    output logic                         dv_out,
    output logic signed [SAMPLE_W-1:0]   real_out,
    output logic signed [SAMPLE_W-1:0]   imag_out,
    output logic [15:0]                  ovf_count
);

    localparam int SUM_W = SAMPLE_W + $clog2(NUM_CHAN + 1);

    cplx_t                      ch_r [NUM_CHAN];
    logic                       v1_r;
    logic                       v2_r;
    logic signed [SAMPLE_W-1:0] noise_re_s;
    logic signed [SAMPLE_W-1:0] noise_im_s;
    logic signed [SUM_W-1:0]    acc_re_s;
    logic signed [SUM_W-1:0]    acc_im_s;
    logic signed [SUM_W-1:0]    sum_re_r;
    logic signed [SUM_W-1:0]    sum_im_r;
    logic signed [SUM_W-1:0]    shr_re_s;
    logic signed [SUM_W-1:0]    shr_im_s;
    logic signed [SAMPLE_W-1:0] sat_re_s;
    logic signed [SAMPLE_W-1:0] sat_im_s;
    logic                       clip_re_s;
    logic                       clip_im_s;

`ifdef SAT_COMBINER_NOISE_EN
    noise_gen u_noise_gen (
        .clk      (clk),
        .reset    (reset),
        .advance  (dv_in),
        .gain     (noise_gain),
        .noise_re (noise_re_s),
        .noise_im (noise_im_s)
    );
`else
    logic unused_noise_gain_s;
    assign unused_noise_gain_s = ^noise_gain;
    assign noise_re_s = 16'sd0;
    assign noise_im_s = 16'sd0;
`endif

    // Returns {clip, value}: value fits when all bits from the 16-bit sign up agree.
    function automatic logic [SAMPLE_W:0] saturate(input logic signed [SUM_W-1:0] v);
        if ((&v[SUM_W-1:SAMPLE_W-1]) || !(|v[SUM_W-1:SAMPLE_W-1])) begin
            return {1'b0, v[SAMPLE_W-1:0]};
        end else if (v[SUM_W-1]) begin
            return {1'b1, 1'b1, {(SAMPLE_W-1){1'b0}}};
        end else begin
            return {1'b1, 1'b0, {(SAMPLE_W-1){1'b1}}};
        end
    endfunction

    // Stage 1: capture masked channel samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            v1_r <= 1'b0;
            for (int i = 0; i < NUM_CHAN; i++) begin
                ch_r[i] <= CPLX_ZERO;
            end
        end else begin
            v1_r <= dv_in;
            if (dv_in) begin
                for (int i = 0; i < NUM_CHAN; i++) begin
                    ch_r[i] <= chan_en[i] ?
                        cplx_t'({real_in[i*SAMPLE_W +: SAMPLE_W], imag_in[i*SAMPLE_W +: SAMPLE_W]}) :
                        CPLX_ZERO;
                end
            end
        end
    end

    // Adder tree over stage-1 registers, seeded with the noise term.
    always_comb begin
        acc_re_s = SUM_W'(noise_re_s);
        acc_im_s = SUM_W'(noise_im_s);
        for (int i = 0; i < NUM_CHAN; i++) begin
            acc_re_s = acc_re_s + SUM_W'(ch_r[i].re);
            acc_im_s = acc_im_s + SUM_W'(ch_r[i].im);
        end
    end

    // Stage 2: register the full-width sum.
    always_ff @(posedge clk) begin
        if (reset) begin
            v2_r     <= 1'b0;
            sum_re_r <= SUM_W'(0);
            sum_im_r <= SUM_W'(0);
        end else begin
            v2_r <= v1_r;
            if (v1_r) begin
                sum_re_r <= acc_re_s;
                sum_im_r <= acc_im_s;
            end
        end
    end

    // Floor rescale then clamp to the 16-bit output range.
    always_comb begin
        shr_re_s = sum_re_r >>> OUT_SHIFT;
        shr_im_s = sum_im_r >>> OUT_SHIFT;
        {clip_re_s, sat_re_s} = saturate(shr_re_s);
        {clip_im_s, sat_im_s} = saturate(shr_im_s);
    end

    // Stage 3: output registers and clip counter (clear wins over increment).
    always_ff @(posedge clk) begin
        if (reset) begin
            dv_out    <= 1'b0;
            real_out  <= 16'sd0;
            imag_out  <= 16'sd0;
            ovf_count <= 16'd0;
        end else begin
            dv_out <= v2_r;
            if (v2_r) begin
                real_out <= sat_re_s;
                imag_out <= sat_im_s;
            end
            if (ovf_clr) begin
                ovf_count <= 16'd0;
            end else if (v2_r && (clip_re_s || clip_im_s) && (ovf_count != 16'hFFFF)) begin
                ovf_count <= ovf_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_sat_combiner.sv
// Self-checking bench for sat_combiner: two instances (OUT_SHIFT 3 and 0) share
// stimulus and are compared each cycle against a queue-based sample model.
module tb_sat_combiner;

    localparam int NCH = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset;
    logic                 dv_in;
    logic [NCH*16-1:0]    real_in;
    logic [NCH*16-1:0]    imag_in;
    logic [NCH-1:0]       chan_en;
    logic [15:0]          noise_gain;
    logic                 ovf_clr;
    logic                 dv3, dv0;
    logic signed [15:0]   re3, im3, re0, im0;
    logic [15:0]          ovf3, ovf0;

    sat_combiner #(.NUM_CHAN(NCH), .OUT_SHIFT(3)) dut_s3 (
        .clk(clk), .reset(reset), .dv_in(dv_in), .real_in(real_in), .imag_in(imag_in),
        .chan_en(chan_en), .noise_gain(noise_gain), .ovf_clr(ovf_clr),
        .dv_out(dv3), .real_out(re3), .imag_out(im3), .ovf_count(ovf3)
    );

    sat_combiner #(.NUM_CHAN(NCH), .OUT_SHIFT(0)) dut_s0 (
        .clk(clk), .reset(reset), .dv_in(dv_in), .real_in(real_in), .imag_in(imag_in),
        .chan_en(chan_en), .noise_gain(noise_gain), .ovf_clr(ovf_clr),
        .dv_out(dv0), .real_out(re0), .imag_out(im0), .ovf_count(ovf0)
    );

    typedef struct {
        int due;
        int re3, im3, re0, im0;
        bit clip3, clip0;
    } item_t;

    item_t       pend[$];
    int          cyc;
    bit          m_dv;
    int          m_re3, m_im3, m_re0, m_im0, m_ovf3, m_ovf0;
    logic [31:0] lfsr_re, lfsr_im;
    int          num_checks;
    int          num_fails;

    task automatic check_eq(input string tag, input int obs, input int exp);
        num_checks++;
        if (obs != exp) begin
            num_fails++;
            $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic bit out_of_range(input int v);
        return (v > 32767) || (v < -32768);
    endfunction

    function automatic int clamp16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic int noise_of(input logic [31:0] s, input int gain);
        int  n;
        byte sb;
        n = 0;
        for (int b = 0; b < 4; b++) begin
            sb = s[8*b +: 8];
            n += sb;
        end
        return (n * gain) >>> 10;
    endfunction

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? 32'h8020_0003 : 32'h0000_0000);
    endfunction

    // Model update for one rising edge, using the inputs presented at that edge.
    task automatic model_edge();
        item_t it;
        int    sr, si, nre, nim;
        bit    c3, c0;
        if (reset) begin
            pend.delete();
            m_dv = 1'b0;
            m_re3 = 0; m_im3 = 0; m_re0 = 0; m_im0 = 0;
            m_ovf3 = 0; m_ovf0 = 0;
            lfsr_re = 32'h1234_5678;
            lfsr_im = 32'h9ABC_DEF0;
        end else begin
            c3 = 1'b0;
            c0 = 1'b0;
            m_dv = 1'b0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                it = pend.pop_front();
                m_dv = 1'b1;
                m_re3 = it.re3; m_im3 = it.im3; m_re0 = it.re0; m_im0 = it.im0;
                c3 = it.clip3;
                c0 = it.clip0;
            end
            if (ovf_clr) begin
                m_ovf3 = 0;
                m_ovf0 = 0;
            end else begin
                if (c3 && m_ovf3 < 65535) m_ovf3++;
                if (c0 && m_ovf0 < 65535) m_ovf0++;
            end
            if (dv_in) begin
`ifdef SAT_COMBINER_NOISE_EN
                nre = noise_of(lfsr_re, int'(noise_gain));
                nim = noise_of(lfsr_im, int'(noise_gain));
                lfsr_re = lfsr_next(lfsr_re);
                lfsr_im = lfsr_next(lfsr_im);
`else
                nre = 0;
                nim = 0;
`endif
                sr = nre;
                si = nim;
                for (int i = 0; i < NCH; i++) begin
                    if (chan_en[i]) begin
                        sr += $signed(real_in[16*i +: 16]);
                        si += $signed(imag_in[16*i +: 16]);
                    end
                end
                it.due   = cyc + 2;
                it.re3   = clamp16(sr >>> 3);
                it.im3   = clamp16(si >>> 3);
                it.re0   = clamp16(sr);
                it.im0   = clamp16(si);
                it.clip3 = out_of_range(sr >>> 3) || out_of_range(si >>> 3);
                it.clip0 = out_of_range(sr) || out_of_range(si);
                pend.push_back(it);
            end
        end
        cyc++;
    endtask

    task automatic compare_all();
        check_eq("dv_out_s3", int'(dv3), int'(m_dv));
        check_eq("dv_out_s0", int'(dv0), int'(m_dv));
        check_eq("real_out_s3", int'(re3), m_re3);
        check_eq("imag_out_s3", int'(im3), m_im3);
        check_eq("real_out_s0", int'(re0), m_re0);
        check_eq("imag_out_s0", int'(im0), m_im0);
        check_eq("ovf_count_s3", int'(ovf3), m_ovf3);
        check_eq("ovf_count_s0", int'(ovf0), m_ovf0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic set_ch(input int i, input int re, input int im);
        real_in[16*i +: 16] = re[15:0];
        imag_in[16*i +: 16] = im[15:0];
    endtask

    task automatic set_all(input int re, input int im);
        for (int i = 0; i < NCH; i++) set_ch(i, re, im);
    endtask

    initial begin
        num_checks = 0;
        num_fails  = 0;
        cyc        = 0;
        reset      = 1'b1;
        dv_in      = 1'b0;
        real_in    = '0;
        imag_in    = '0;
        chan_en    = 8'hFF;
        noise_gain = 16'd0;
        ovf_clr    = 1'b0;
        repeat (3) tick();
        check_eq("reset_ovf_s0", int'(ovf0), 0);
        reset = 1'b0;
        tick();

        // Single channel, exact latency and scaling
        set_ch(0, 1000, 0);
        dv_in = 1'b1;
        tick();
        dv_in = 1'b0;
        tick();
        check_eq("latency_dv_early", int'(dv3), 0);
        tick();
        check_eq("latency_dv", int'(dv3), 1);
        check_eq("ch0_1000_shift3", int'(re3), 125);
        repeat (3) tick();
        check_eq("hold_after_valid", int'(re3), 125);

        // Positive and negative full scale
        set_all(32767, 0);
        dv_in = 1'b1;
        repeat (10) tick();
        check_eq("pos_clip_s0", int'(re0), 32767);
        set_all(-32768, -32768);
        repeat (10) tick();
        check_eq("neg_clip_s0", int'(re0), -32768);
        check_eq("neg_fit_s3", int'(re3), -32768);

        // Drive the clip counter into saturation, then clear against a clip
        set_all(32767, 0);
        repeat (65540) tick();
        check_eq("ovf_saturated", int'(ovf0), 65535);
        ovf_clr = 1'b1;
        tick();
        check_eq("ovf_clr_priority", int'(ovf0), 0);
        ovf_clr = 1'b0;
        tick();
        check_eq("ovf_after_clr", int'(ovf0), 1);
        dv_in = 1'b0;
        repeat (4) tick();

        // Channel masking and enable changes between samples
        set_all(0, 0);
        set_ch(0, 100, 0);
        set_ch(1, 4000, -4000);
        chan_en = 8'h01;
        dv_in = 1'b1;
        tick();
        dv_in = 1'b0;
        repeat (3) tick();
        check_eq("masked_ch1", int'(re0), 100);
        for (int k = 0; k < 6; k++) begin
            chan_en = (k % 2 == 0) ? 8'h03 : 8'h01;
            dv_in = 1'b1;
            tick();
            chan_en = (k % 2 == 0) ? 8'h01 : 8'h03;
            dv_in = 1'b0;
            tick();
        end
        repeat (4) tick();

        // Randomized traffic with gaps, masks, gain and occasional clears
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 1) == 0) begin
                real_in = {$urandom, $urandom, $urandom, $urandom};
                imag_in = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                for (int i = 0; i < NCH; i++)
                    set_ch(i, int'($urandom_range(0, 8191)) - 4096, int'($urandom_range(0, 8191)) - 4096);
            end
            chan_en    = NCH'($urandom);
            noise_gain = 16'($urandom);
            dv_in      = ($urandom_range(0, 3) != 0);
            ovf_clr    = ($urandom_range(0, 63) == 0);
            tick();
        end
        dv_in = 1'b0;
        ovf_clr = 1'b0;
        noise_gain = 16'd0;
        repeat (4) tick();

        // Reset with three samples in flight
        chan_en = 8'hFF;
        set_all(500, -300);
        dv_in = 1'b1;
        repeat (3) tick();
        dv_in = 1'b0;
        reset = 1'b1;
        tick();
        check_eq("reset_flush_dv", int'(dv3), 0);
        check_eq("reset_flush_re", int'(re3), 0);
        reset = 1'b0;
        repeat (6) tick();
        dv_in = 1'b1;
        tick();
        dv_in = 1'b0;
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
